// File: rtl/vga_rd_ctrl_pkg.sv
// Shared definitions for the VGA frame read controller.
//   - FSM state encoding
//   - default frame geometry (matches the VGA timing defaults)
//   - default frame bank base addresses and burst length
//   - read length width and the burst-length clipping helper
package vga_rd_ctrl_pkg;

    localparam int unsigned H_ACT_DEF      = 1280;
    localparam int unsigned V_ACT_DEF      = 720;
    localparam int unsigned BURST_LEN_DEF  = 64;
    localparam int unsigned ADDR_W_DEF     = 24;
    localparam logic [23:0] BANK0_BASE_DEF = 24'h000000;
    localparam logic [23:0] BANK1_BASE_DEF = 24'h100000;

    // rd_len must hold 1..256
    localparam int unsigned LEN_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_CHECK = 3'd2,
        ST_REQ   = 3'd3,
        ST_DATA  = 3'd4
    } rd_state_e;

    // Length of the next burst: a full burst, or whatever is left of the frame.
    function automatic logic [LEN_W-1:0] clip_len(input logic [31:0] remaining,
                                                  input logic [31:0] burst);
        logic [LEN_W-1:0] len;
        if (remaining < burst) begin
            len = remaining[LEN_W-1:0];
        end else begin
            len = burst[LEN_W-1:0];
        end
        return len;
    endfunction

endpackage

// File: rtl/vga_rd_bank_sel.sv
// Ping-pong bank tracker for the frame read controller.
// Remembers the most recently completed write bank and whether any frame has
// been completed at all; the displayed bank is only updated when the read
// FSM arms a new frame, so write completions mid-frame never disturb it.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_frame_done_i   write side finished a frame (one-cycle pulse)
//   wr_bank_i         bank just completed, sampled with wr_frame_done_i
//   arm_i             read FSM is arming a new frame
//   last_bank_o       most recently completed bank
//   bank_valid_o      at least one frame completed since reset
//   rd_bank_o         bank currently being displayed
module vga_rd_bank_sel
    import vga_rd_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic wr_frame_done_i,
    input  logic wr_bank_i,
    input  logic arm_i,
    output logic last_bank_o,
    output logic bank_valid_o,
    output logic rd_bank_o
);

    logic last_bank_q, last_bank_d;
    logic bank_valid_q, bank_valid_d;
    logic rd_bank_q, rd_bank_d;

    // Next-state for the completed-bank record and the displayed bank.
    always_comb begin
        last_bank_d  = last_bank_q;
        bank_valid_d = bank_valid_q;
        rd_bank_d    = rd_bank_q;
        if (wr_frame_done_i) begin
            last_bank_d  = wr_bank_i;
            bank_valid_d = 1'b1;
        end else begin
            last_bank_d  = last_bank_q;
            bank_valid_d = bank_valid_q;
        end
        // Uses the registered last bank, so a completion in the arm cycle
        // applies to the following frame.
        if (arm_i) begin
            rd_bank_d = last_bank_q;
        end else begin
            rd_bank_d = rd_bank_q;
        end
    end

    // Bank state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_bank_q  <= 1'b0;
            bank_valid_q <= 1'b0;
            rd_bank_q    <= 1'b0;
        end else begin
            last_bank_q  <= last_bank_d;
            bank_valid_q <= bank_valid_d;
            rd_bank_q    <= rd_bank_d;
        end
    end

    assign last_bank_o  = last_bank_q;
    assign bank_valid_o = bank_valid_q;
    assign rd_bank_o    = rd_bank_q;

endmodule

// File: rtl/vga_rd_ctrl.sv
// Frame read controller feeding the VGA output stage.
// Issues burst reads to the SDRAM arbiter for the most recently completed
// frame bank and forwards returned RGB565 words to the VGA stage, one clock
// after they arrive. A new burst is only requested while the VGA FIFO asks
// for data (rdy); a burst in flight always runs to completion.
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   rdy                 VGA FIFO wants data (sampled between bursts only)
//   frame_start         start of a VGA frame; restarts a frame in progress
//   wr_frame_done/bank  write side completed a frame into wr_bank
//   rd_req/addr/len     burst request, held until rd_ack
//   rd_ack              arbiter accepted the request
//   rd_data/_vld        returned read beats
//   dout/dout_vld       pixel stream to the VGA stage
//   rd_bank             bank being displayed
//   frame_busy          current frame still has pixels to fetch
module vga_rd_ctrl
    import vga_rd_ctrl_pkg::*;
#(
    parameter int unsigned H_ACT      = H_ACT_DEF,
    parameter int unsigned V_ACT      = V_ACT_DEF,
    parameter int unsigned BURST_LEN  = BURST_LEN_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] BANK0_BASE = ADDR_W'(BANK0_BASE_DEF),
    parameter logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(BANK1_BASE_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              frame_start,
    input  logic              wr_frame_done,
    input  logic              wr_bank,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [LEN_W-1:0]  rd_len,
    input  logic              rd_ack,
    input  logic [15:0]       rd_data,
    input  logic              rd_data_vld,
    output logic [15:0]       dout,
    output logic              dout_vld,
    output logic              rd_bank,
    output logic              frame_busy
);

    localparam int unsigned TOTAL = H_ACT * V_ACT;
    localparam int unsigned REM_W = $clog2(TOTAL + 1);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              restart_q, restart_d;
    logic [15:0]       dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d;

    logic              arm_s;
    logic              last_bank_s;
    logic              bank_valid_s;
    logic [LEN_W-1:0]  beat_inc_s;

    assign arm_s = (state_q == ST_ARM);

    vga_rd_bank_sel u_bank_sel (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_frame_done_i (wr_frame_done),
        .wr_bank_i       (wr_bank),
        .arm_i           (arm_s),
        .last_bank_o     (last_bank_s),
        .bank_valid_o    (bank_valid_s),
        .rd_bank_o       (rd_bank)
    );

    // Read FSM next-state, burst bookkeeping and pixel forwarding.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        len_d      = len_q;
        beat_d     = beat_q;
        req_d      = req_q;
        busy_d     = busy_q;
        restart_d  = restart_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        beat_inc_s = beat_q + 9'd1;

        // A frame start while a frame is underway is remembered and acted
        // on at the next burst boundary; CHECK consumes it directly below.
        if (frame_start && (state_q != ST_IDLE)) begin
            restart_d = 1'b1;
        end else begin
            restart_d = restart_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start && bank_valid_s) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                addr_d  = last_bank_s ? BANK1_BASE : BANK0_BASE;
                rem_d   = REM_W'(TOTAL);
                busy_d  = 1'b1;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (restart_q || frame_start) begin
                    restart_d = 1'b0;
                    state_d   = ST_ARM;
                end else if (rem_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (rdy) begin
                    len_d   = clip_len(32'(rem_q), 32'(BURST_LEN));
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_REQ: begin
                if (rd_ack) begin
                    req_d   = 1'b0;
                    beat_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DATA: begin
                dout_d     = rd_data;
                dout_vld_d = rd_data_vld;
                if (rd_data_vld) begin
                    if (beat_inc_s == len_q) begin
                        addr_d  = addr_q + ADDR_W'(len_q);
                        rem_d   = rem_q - REM_W'(len_q);
                        beat_d  = '0;
                        state_d = ST_CHECK;
                    end else begin
                        beat_d = beat_inc_s;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                req_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            restart_q  <= 1'b0;
            dout_q     <= 16'h0000;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            restart_q  <= restart_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign rd_req     = req_q;
    assign rd_addr    = addr_q;
    assign rd_len     = len_q;
    assign dout       = dout_q;
    assign dout_vld   = dout_vld_q;
    assign frame_busy = busy_q;

endmodule

// File: tb/tb_vga_rd_ctrl.sv
// Scoreboard bench for vga_rd_ctrl with a small 100x2 frame (200 pixels:
// bursts of 64, 64, 64, 8). An arbiter/memory process answers requests with
// random ack delay, random beat gaps and random data; expected requests come
// from a per-frame burst list and expected pixels from the beats handed out.
module tb_vga_rd_ctrl;

    localparam int unsigned H_ACT  = 100;
    localparam int unsigned V_ACT  = 2;
    localparam int unsigned BURST  = 64;
    localparam logic [23:0] B0     = 24'h000000;
    localparam logic [23:0] B1     = 24'h100000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic        frame_start = 1'b0;
    logic        wr_frame_done = 1'b0;
    logic        wr_bank = 1'b0;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic [8:0]  rd_len;
    logic        rd_ack = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        rd_data_vld = 1'b0;
    logic [15:0] dout;
    logic        dout_vld;
    logic        rd_bank;
    logic        frame_busy;

    typedef struct { logic [23:0] addr; int len; } req_t;
    typedef struct { logic [15:0] data; int cyc; } beat_t;

    req_t  exp_req[$];
    beat_t exp_dout[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    burst_cnt = 0;
    int    beat_idx = 0;
    bit    model_last_bank = 1'b0;
    bit    model_valid = 1'b0;

    vga_rd_ctrl #(
        .H_ACT      (H_ACT),
        .V_ACT      (V_ACT),
        .BURST_LEN  (BURST),
        .ADDR_W     (24),
        .BANK0_BASE (B0),
        .BANK1_BASE (B1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdy           (rdy),
        .frame_start   (frame_start),
        .wr_frame_done (wr_frame_done),
        .wr_bank       (wr_bank),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_len        (rd_len),
        .rd_ack        (rd_ack),
        .rd_data       (rd_data),
        .rd_data_vld   (rd_data_vld),
        .dout          (dout),
        .dout_vld      (dout_vld),
        .rd_bank       (rd_bank),
        .frame_busy    (frame_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_note(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got 0x%0h, nothing was expected (cycle %0d)", name, act, cyc);
    endtask

    // Reference model: a frame is TOTAL pixels fetched in BURST-sized chunks
    // from the bank base, the last chunk holding whatever is left.
    task automatic push_frame(input bit bank);
        int          rem;
        logic [23:0] a;
        req_t        r;
        rem = int'(H_ACT * V_ACT);
        a   = bank ? B1 : B0;
        while (rem > 0) begin
            r.addr = a;
            r.len  = (rem < int'(BURST)) ? rem : int'(BURST);
            exp_req.push_back(r);
            a   = a + 24'(r.len);
            rem = rem - r.len;
        end
    endtask

    task automatic pulse_fs();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wr_pulse(input bit b);
        @(negedge clk);
        wr_frame_done = 1'b1;
        wr_bank = b;
        model_last_bank = b;
        model_valid = 1'b1;
        @(negedge clk);
        wr_frame_done = 1'b0;
    endtask

    task automatic start_frame();
        push_frame(model_last_bank);
        pulse_fs();
        @(negedge clk);
        check("frame_busy_rise", 32'(frame_busy), 32'd1);
        check("rd_bank_at_arm", 32'(rd_bank), 32'(model_last_bank));
    endtask

    task automatic wait_frame(input bit rand_rdy);
        int n;
        n = 0;
        while (frame_busy && n < 20000) begin
            @(negedge clk);
            if (rand_rdy) rdy = 1'($urandom_range(0, 1));
            n++;
        end
        if (n >= 20000) fail_note("frame_timeout", 32'(n));
        rdy = 1'b1;
        repeat (4) @(negedge clk);
        check("req_list_drained", 32'(exp_req.size()), 32'd0);
        check("dout_list_drained", 32'(exp_dout.size()), 32'd0);
    endtask

    task automatic wait_beat(input int bc0, input int beat);
        int n;
        n = 0;
        while (!(burst_cnt == bc0 + 1 && beat_idx >= beat) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) fail_note("beat_wait_timeout", 32'(n));
    endtask

    // Arbiter + memory model: checks each request against the expected burst
    // list, acks after a random delay, then returns len beats with gaps.
    initial begin : arbiter
        req_t r;
        bit   dead;
        int   len;
        forever begin
            @(negedge clk);
            rd_ack = 1'b0;
            rd_data_vld = 1'b0;
            if (rst_n && rd_req) begin
                dead = 1'b0;
                len  = int'(rd_len);
                r.addr = 24'h0;
                r.len  = 0;
                if (exp_req.size() == 0) begin
                    fail_note("unexpected_req", 32'(rd_addr));
                    dead = 1'b1;
                end else begin
                    r = exp_req.pop_front();
                    check("req_addr", 32'(rd_addr), 32'(r.addr));
                    check("req_len", 32'(rd_len), 32'(r.len));
                end
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    check("req_held", 32'(rd_req), 32'd1);
                    if (!dead) check("req_addr_held", 32'(rd_addr), 32'(r.addr));
                end
                rd_ack = 1'b1;
                @(negedge clk);
                rd_ack = 1'b0;
                check("req_drop_after_ack", 32'(rd_req), 32'd0);
                burst_cnt++;
                beat_idx = 0;
                while (beat_idx < len) begin
                    if (!rst_n) dead = 1'b1;
                    if ($urandom_range(0, 3) == 0) begin
                        rd_data_vld = 1'b0;
                    end else begin
                        rd_data_vld = 1'b1;
                        rd_data = 16'($urandom);
                        if (!dead) exp_dout.push_back('{data: rd_data, cyc: cyc});
                        beat_idx++;
                    end
                    @(negedge clk);
                end
                rd_data_vld = 1'b0;
            end else if (rst_n && $urandom_range(0, 7) == 0) begin
                // stray beat outside any burst: must not reach the VGA stage
                rd_data_vld = 1'b1;
                rd_data = 16'($urandom);
            end
        end
    end

    // Pixel monitor: every forwarded pixel must match the next expected beat,
    // exactly one clock after it was presented.
    always @(negedge clk) begin
        beat_t b;
        if (dout_vld) begin
            if (exp_dout.size() == 0) begin
                fail_note("unexpected_dout", 32'(dout));
            end else begin
                b = exp_dout.pop_front();
                check("dout_data", 32'(dout), 32'(b.data));
                check("dout_latency", 32'(cyc), 32'(b.cyc + 1));
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        int bc0;
        int cnt;
        // reset state
        #1;
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_dout_vld", 32'(dout_vld), 32'd0);
        check("rst_frame_busy", 32'(frame_busy), 32'd0);
        check("rst_rd_len", 32'(rd_len), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // frame starts without any completed write frame: no reads
        cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            frame_start = ((i % 250) == 10);
            if (rd_req || dout_vld || frame_busy) cnt++;
        end
        frame_start = 1'b0;
        check("no_bank_activity", 32'(cnt), 32'd0);

        // first frame from bank 1, rdy held high
        wr_pulse(1'b1);
        rdy = 1'b1;
        start_frame();
        wait_frame(1'b0);
        check("frame_busy_fall", 32'(frame_busy), 32'd0);
        check("rd_bank_frame1", 32'(rd_bank), 32'd1);

        // rdy low in CHECK: nothing requested; frame_start in CHECK re-arms
        rdy = 1'b0;
        start_frame();
        cnt = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (rd_req) cnt++;
        end
        check("rdy_low_no_req", 32'(cnt), 32'd0);
        check("rdy_low_busy", 32'(frame_busy), 32'd1);
        wr_pulse(1'b0);
        exp_req.delete();
        push_frame(1'b0);
        pulse_fs();
        repeat (2) @(negedge clk);
        check("check_restart_bank", 32'(rd_bank), 32'd0);
        rdy = 1'b1;
        @(negedge clk);
        check("rdy_high_req", 32'(rd_req), 32'd1);
        check("rdy_high_addr", 32'(rd_addr), 32'(B0));
        wait_frame(1'b1);

        // bank switch mid-frame must wait for the next frame
        wr_pulse(1'b1);
        bc0 = burst_cnt;
        start_frame();
        wait_beat(bc0, 5);
        wr_pulse(1'b0);
        check("rd_bank_hold_mid", 32'(rd_bank), 32'd1);
        wait_frame(1'b1);
        check("rd_bank_hold_end", 32'(rd_bank), 32'd1);
        start_frame();
        wait_frame(1'b0);
        check("rd_bank_switched", 32'(rd_bank), 32'd0);

        // frame_start mid-burst: burst completes, then frame restarts
        bc0 = burst_cnt;
        start_frame();
        wait_beat(bc0, 10);
        wr_pulse(1'b1);
        exp_req.delete();
        push_frame(1'b1);
        pulse_fs();
        wait_frame(1'b0);
        check("rd_bank_after_restart", 32'(rd_bank), 32'd1);

        // asynchronous reset in the middle of a burst
        bc0 = burst_cnt;
        start_frame();
        wait_beat(bc0, 20);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_dout.delete();
        exp_req.delete();
        model_valid = 1'b0;
        #1;
        check("mid_rst_rd_req", 32'(rd_req), 32'd0);
        check("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
        check("mid_rst_rd_len", 32'(rd_len), 32'd0);
        check("mid_rst_dout", 32'(dout), 32'd0);
        check("mid_rst_dout_vld", 32'(dout_vld), 32'd0);
        check("mid_rst_rd_bank", 32'(rd_bank), 32'd0);
        check("mid_rst_frame_busy", 32'(frame_busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pulse_fs();
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rd_req || frame_busy) cnt++;
        end
        check("post_rst_no_reads", 32'(cnt), 32'd0);
        check("post_rst_dout_list", 32'(exp_dout.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
